// File: rtl/cp0_exc_ctrl.sv
// CP0 register file and exception sequencer: MTC0/MFC0 access, exception entry,
// ERET, Count/Compare timer, interrupt request and pipeline flush/redirect.
module cp0_exc_ctrl #(
  parameter logic [31:0] EXC_VECTOR = 32'hBFC0_0380,
  parameter logic [31:0] STATUS_RST = 32'h0040_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cp0_write_en,
  input  logic        cp0_read_en,
  input  logic [7:0]  cp0_addr,
  input  logic [31:0] cp0_write_data,
  output logic [31:0] cp0_read_data,
  input  logic        exc_valid,
  input  logic [4:0]  exc_code,
  input  logic [31:0] exc_pc,
  input  logic        exc_bd,
  input  logic [31:0] exc_badvaddr,
  input  logic        eret,
  input  logic [5:0]  hw_int,
  output logic        int_pending,
  output logic        flush,
  output logic [31:0] redirect_pc,
  output logic [31:0] status,
  output logic [31:0] cause,
  output logic [31:0] epc
);

  localparam logic [7:0]  A_BADVADDR   = 8'h40;
  localparam logic [7:0]  A_COUNT      = 8'h48;
  localparam logic [7:0]  A_COMPARE    = 8'h58;
  localparam logic [7:0]  A_STATUS     = 8'h60;
  localparam logic [7:0]  A_CAUSE      = 8'h68;
  localparam logic [7:0]  A_EPC        = 8'h70;
  localparam logic [31:0] STATUS_WMASK = 32'h0000_FF03;

  logic [31:0] r_status, r_cause, r_epc, r_badvaddr, r_count, r_compare;
  logic [31:0] r_redirect_pc;
  logic        r_tick, r_flush;

  logic [31:0] w_status_nxt, w_cause_nxt, w_epc_nxt, w_badvaddr_nxt;
  logic [31:0] w_count_nxt, w_compare_nxt, w_redirect_nxt;
  logic        w_tick_nxt, w_ti_nxt, w_wr_ok, w_wr_count, w_wr_compare;

  // Exception and ERET both suppress an MTC0 committing in the same cycle.
  assign w_wr_ok      = cp0_write_en & ~exc_valid & ~eret;
  assign w_wr_count   = w_wr_ok && (cp0_addr == A_COUNT);
  assign w_wr_compare = w_wr_ok && (cp0_addr == A_COMPARE);

  always_comb begin
    w_status_nxt   = r_status;
    w_cause_nxt    = r_cause;
    w_epc_nxt      = r_epc;
    w_badvaddr_nxt = r_badvaddr;
    w_compare_nxt  = r_compare;
    w_redirect_nxt = r_redirect_pc;

    w_count_nxt = r_tick ? r_count + 32'd1 : r_count;
    w_tick_nxt  = ~r_tick;
    if (w_wr_count) begin
      w_count_nxt = cp0_write_data;
      w_tick_nxt  = 1'b0;
    end
    if (w_wr_compare)
      w_compare_nxt = cp0_write_data;

    if (exc_valid) begin
      if (!r_status[1]) begin
        w_epc_nxt       = exc_bd ? exc_pc - 32'd4 : exc_pc;
        w_cause_nxt[31] = exc_bd;
      end
      w_cause_nxt[6:2] = exc_code;
      w_status_nxt[1]  = 1'b1;
      if (exc_code == 5'h04 || exc_code == 5'h05)
        w_badvaddr_nxt = exc_badvaddr;
      w_redirect_nxt = EXC_VECTOR;
    end else if (eret) begin
      w_status_nxt[1] = 1'b0;
      w_redirect_nxt  = r_epc;
    end else if (w_wr_ok) begin
      case (cp0_addr)
        A_STATUS: w_status_nxt = (STATUS_RST & ~STATUS_WMASK) | (cp0_write_data & STATUS_WMASK);
        A_CAUSE:  w_cause_nxt[9:8] = cp0_write_data[9:8];
        A_EPC:    w_epc_nxt = cp0_write_data;
        default:  ;
      endcase
    end

    // TI tracks the post-update Count so IP[7] and int_pending move with it.
    w_ti_nxt           = w_wr_compare ? 1'b0 : (r_cause[30] | (w_count_nxt == r_compare));
    w_cause_nxt[30]    = w_ti_nxt;
    w_cause_nxt[15:10] = {hw_int[5] | w_ti_nxt, hw_int[4:0]};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_status      <= STATUS_RST;
      r_cause       <= 32'd0;
      r_epc         <= 32'd0;
      r_badvaddr    <= 32'd0;
      r_count       <= 32'd0;
      r_compare     <= 32'd0;
      r_tick        <= 1'b0;
      r_flush       <= 1'b0;
      r_redirect_pc <= 32'd0;
    end else begin
      r_status      <= w_status_nxt;
      r_cause       <= w_cause_nxt;
      r_epc         <= w_epc_nxt;
      r_badvaddr    <= w_badvaddr_nxt;
      r_count       <= w_count_nxt;
      r_compare     <= w_compare_nxt;
      r_tick        <= w_tick_nxt;
      r_flush       <= exc_valid | eret;
      r_redirect_pc <= w_redirect_nxt;
    end
  end

  always_comb begin
    cp0_read_data = 32'd0;
    if (cp0_read_en) begin
      case (cp0_addr)
        A_BADVADDR: cp0_read_data = r_badvaddr;
        A_COUNT:    cp0_read_data = r_count;
        A_COMPARE:  cp0_read_data = r_compare;
        A_STATUS:   cp0_read_data = r_status;
        A_CAUSE:    cp0_read_data = r_cause;
        A_EPC:      cp0_read_data = r_epc;
        default:    cp0_read_data = 32'd0;
      endcase
    end
  end

  assign int_pending = r_status[0] & ~r_status[1] & |(r_cause[15:8] & r_status[15:8]);
  assign flush       = r_flush;
  assign redirect_pc = r_redirect_pc;
  assign status      = r_status;
  assign cause       = r_cause;
  assign epc         = r_epc;

endmodule
